// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/DE/MW pipeline.
// It produces the MW->DE forwarding selects, the stage stall/flush controls,
// and the trap-entry sequence for interrupts and data-memory timeouts.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_DE,
  input  logic [4:0] rs2_DE,
  input  logic [4:0] rd_MW,
  input  logic       reg_wrMW,
  input  logic       rd_enMW,
  input  logic       wr_enMW,
  input  logic       dmem_ack,
  input  logic       br_taken,
  input  logic       intr_pending,
  input  logic       is_mretMW,
  output logic       fwd_a,
  output logic       fwd_b,
  output logic       stall_IF,
  output logic       stall_DE,
  output logic       stall_MW,
  output logic       flush_IF,
  output logic       flush_DE,
  output logic       trap_take,
  output logic       trap_cause,
  output logic       bus_err
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cause_q, cause_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_req;
  logic             stall;

  assign mem_req = rd_enMW | wr_enMW;

  // Forwarding selects depend only on the DE sources and the MW destination.
  always_comb begin
    fwd_a = reg_wrMW & (rd_MW != 5'd0) & (rd_MW == rs1_DE);
    fwd_b = reg_wrMW & (rd_MW != 5'd0) & (rd_MW == rs2_DE);
  end

  // Next-state logic and the combinational stall/flush/trap controls.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    bus_err_d  = 1'b0;
    stall      = 1'b0;
    flush_IF   = 1'b0;
    flush_DE   = 1'b0;
    trap_take  = 1'b0;
    trap_cause = 1'b0;
    if (reset) begin
      // Bubbles go into both stage registers while the core is held in reset.
      flush_IF = 1'b1;
      flush_DE = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !dmem_ack) begin
            stall   = 1'b1;
            state_d = ST_MEM_WAIT;
            cnt_d   = CNT_ONE;
          end else if (intr_pending) begin
            // The MW instruction retires normally; the trap follows next cycle.
            state_d = ST_TRAP;
            cause_d = 1'b0;
          end else if (is_mretMW) begin
            flush_IF = 1'b1;
            flush_DE = 1'b1;
          end else if (br_taken) begin
            flush_IF = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          stall = !dmem_ack;
          if (dmem_ack) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = ST_TRAP;
            cause_d   = 1'b1;
            bus_err_d = 1'b1;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_TRAP: begin
          trap_take  = 1'b1;
          trap_cause = cause_q;
          flush_IF   = 1'b1;
          flush_DE   = 1'b1;
          cnt_d      = '0;
          state_d    = ST_REDIRECT;
        end
        default: begin
          // Discard the fetch issued from the pre-trap PC.
          flush_IF = 1'b1;
          state_d  = ST_RUN;
        end
      endcase
    end
  end

  assign stall_IF = stall;
  assign stall_DE = stall;
  assign stall_MW = stall;
  assign bus_err  = bus_err_q & ~reset;

  // State, wait counter, trap cause and the bus-error pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      cause_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a vector table for the
// single-cycle decisions, hand-written multi-cycle sequences, and a random
// run compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_wr;
    logic       rd_en;
    logic       wr_en;
    logic       ack;
    logic       br;
    logic       intr;
    logic       mret;
  } in_t;

  typedef struct {
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  // Output bit order: fwd_a fwd_b stall_IF stall_DE stall_MW flush_IF flush_DE trap_take trap_cause bus_err
  localparam logic [9:0] O_IDLE  = 10'b00_000_00_000;
  localparam logic [9:0] O_STALL = 10'b00_111_00_000;
  localparam logic [9:0] O_FL2   = 10'b00_000_11_000;
  localparam logic [9:0] O_FL1   = 10'b00_000_10_000;
  localparam logic [9:0] O_TRAPI = 10'b00_000_11_100;
  localparam logic [9:0] O_TRAPB = 10'b00_000_11_111;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_DE, rs2_DE, rd_MW;
  logic reg_wrMW, rd_enMW, wr_enMW, dmem_ack, br_taken, intr_pending, is_mretMW;
  logic fwd_a, fwd_b, stall_IF, stall_DE, stall_MW, flush_IF, flush_DE;
  logic trap_take, trap_cause, bus_err;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Behavioural model state: stall cycles spent on the current miss, a
  // scheduled trap (-1 none, else its cause), a pending redirect, bus-error flop.
  int miss_len = 0;
  int trap_sched = -1;
  bit redirect = 1'b0;
  bit berr = 1'b0;

  vec_t vecs[12];
  in_t s;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .rs1_DE(rs1_DE), .rs2_DE(rs2_DE), .rd_MW(rd_MW),
    .reg_wrMW(reg_wrMW), .rd_enMW(rd_enMW), .wr_enMW(wr_enMW),
    .dmem_ack(dmem_ack), .br_taken(br_taken),
    .intr_pending(intr_pending), .is_mretMW(is_mretMW),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_IF(stall_IF), .stall_DE(stall_DE), .stall_MW(stall_MW),
    .flush_IF(flush_IF), .flush_DE(flush_DE),
    .trap_take(trap_take), .trap_cause(trap_cause), .bus_err(bus_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input in_t v);
    reset        = v.rst;
    rs1_DE       = v.rs1;
    rs2_DE       = v.rs2;
    rd_MW        = v.rd;
    reg_wrMW     = v.reg_wr;
    rd_enMW      = v.rd_en;
    wr_enMW      = v.wr_en;
    dmem_ack     = v.ack;
    br_taken     = v.br;
    intr_pending = v.intr;
    is_mretMW    = v.mret;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {fwd_a, fwd_b, stall_IF, stall_DE, stall_MW, flush_IF, flush_DE,
           trap_take, trap_cause, bus_err};
    if (!exp[2]) act[1] = exp[1];
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input in_t v, input logic [9:0] exp);
    applyStimulus(v);
    checkOutput(name, exp);
    advance();
  endtask

  function automatic logic [9:0] modelOut(input in_t v);
    logic fa, fb, st, fi, fd, tt, tc, be;
    fa = v.reg_wr && (v.rd != 5'd0) && (v.rd == v.rs1);
    fb = v.reg_wr && (v.rd != 5'd0) && (v.rd == v.rs2);
    {st, fi, fd, tt, tc, be} = 6'b0;
    if (v.rst) begin
      fi = 1'b1;
      fd = 1'b1;
    end else begin
      be = berr;
      if (trap_sched >= 0) begin
        tt = 1'b1;
        tc = (trap_sched == 1);
        fi = 1'b1;
        fd = 1'b1;
      end else if (redirect) begin
        fi = 1'b1;
      end else if (miss_len > 0) begin
        st = !v.ack;
      end else if ((v.rd_en || v.wr_en) && !v.ack) begin
        st = 1'b1;
      end else if (v.intr) begin
        st = 1'b0;
      end else if (v.mret) begin
        fi = 1'b1;
        fd = 1'b1;
      end else if (v.br) begin
        fi = 1'b1;
      end
    end
    return {fa, fb, st, st, st, fi, fd, tt, tc, be};
  endfunction

  task automatic modelStep(input in_t v);
    if (v.rst) begin
      miss_len = 0;
      trap_sched = -1;
      redirect = 1'b0;
      berr = 1'b0;
    end else begin
      berr = 1'b0;
      if (trap_sched >= 0) begin
        trap_sched = -1;
        redirect = 1'b1;
      end else if (redirect) begin
        redirect = 1'b0;
      end else if (miss_len > 0) begin
        if (v.ack) miss_len = 0;
        else if (miss_len == TMO) begin
          miss_len = 0;
          trap_sched = 1;
          berr = 1'b1;
        end else miss_len++;
      end else if ((v.rd_en || v.wr_en) && !v.ack) begin
        miss_len = 1;
      end else if (v.intr) begin
        trap_sched = 0;
      end
    end
  endtask

  initial begin
    // Single-cycle decisions taken from RUN; none of these leave RUN.
    for (int i = 0; i < 12; i++) begin
      vecs[i].in = '0;
      vecs[i].exp = O_IDLE;
    end
    vecs[0].in.reg_wr = 1; vecs[0].in.rd = 5; vecs[0].in.rs1 = 5; vecs[0].in.rs2 = 5;
    vecs[0].exp = 10'b11_000_00_000;
    vecs[1].in.reg_wr = 1; vecs[1].exp = O_IDLE;
    vecs[2].in.rd = 5; vecs[2].in.rs1 = 5; vecs[2].in.rs2 = 5; vecs[2].exp = O_IDLE;
    vecs[3].in.reg_wr = 1; vecs[3].in.rd = 7; vecs[3].in.rs1 = 7; vecs[3].in.rs2 = 3;
    vecs[3].exp = 10'b10_000_00_000;
    vecs[4].in.reg_wr = 1; vecs[4].in.rd = 3; vecs[4].in.rs1 = 7; vecs[4].in.rs2 = 3;
    vecs[4].exp = 10'b01_000_00_000;
    vecs[5].in.mret = 1; vecs[5].in.br = 1; vecs[5].exp = O_FL2;
    vecs[6].in.br = 1; vecs[6].exp = O_FL1;
    vecs[7].in.rd_en = 1; vecs[7].in.ack = 1; vecs[7].in.br = 1; vecs[7].exp = O_FL1;
    vecs[8].in.wr_en = 1; vecs[8].in.ack = 1; vecs[8].in.mret = 1;
    vecs[8].in.reg_wr = 1; vecs[8].in.rd = 9; vecs[8].in.rs1 = 9;
    vecs[8].exp = 10'b10_000_11_000;
    vecs[9].in.rst = 1; vecs[9].in.br = 1; vecs[9].exp = O_FL2;
    vecs[10].in.rst = 1; vecs[10].in.intr = 1; vecs[10].in.rd_en = 1; vecs[10].exp = O_FL2;
    vecs[11].exp = O_IDLE;

    // Reset state.
    s = '0; s.rst = 1;
    step("reset0", s, O_FL2);
    step("reset1", s, O_FL2);

    for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);

    // Load held off for three cycles, then acknowledged.
    s = '0; s.rd_en = 1;
    for (int i = 0; i < 3; i++) step($sformatf("load_wait%0d", i), s, O_STALL);
    s.ack = 1;
    step("load_ack", s, O_IDLE);
    s = '0;
    step("load_after", s, O_IDLE);
    s.br = 1;
    step("load_back_in_run", s, O_FL1);

    // Store never acknowledged: TMO+1 stall cycles, trap, redirect.
    s = '0; s.wr_en = 1;
    for (int i = 0; i <= TMO; i++) step($sformatf("tmo_stall%0d", i), s, O_STALL);
    s = '0;
    step("tmo_trap", s, O_TRAPB);
    s.br = 1; s.intr = 1; s.mret = 1;
    step("tmo_redirect", s, O_FL1);
    s = '0;
    step("tmo_run", s, O_IDLE);

    // Interrupt outranks a taken branch in the same cycle.
    s = '0; s.intr = 1; s.br = 1;
    step("intr_sample", s, O_IDLE);
    s = '0;
    step("intr_trap", s, O_TRAPI);
    step("intr_redirect", s, O_FL1);
    step("intr_run", s, O_IDLE);

    // Interrupt raised during a memory wait is taken only after the ack.
    s = '0; s.rd_en = 1;
    step("mw_intr_miss", s, O_STALL);
    s.intr = 1;
    step("mw_intr_wait", s, O_STALL);
    s.ack = 1;
    step("mw_intr_ack", s, O_IDLE);
    s = '0; s.intr = 1;
    step("mw_intr_run", s, O_IDLE);
    s = '0;
    step("mw_intr_trap", s, O_TRAPI);
    step("mw_intr_redirect", s, O_FL1);

    // Reset on the second wait cycle abandons the sequence.
    s = '0; s.rd_en = 1;
    step("rst_mid_miss", s, O_STALL);
    step("rst_mid_wait1", s, O_STALL);
    s.rst = 1;
    step("rst_mid_reset", s, O_FL2);
    s = '0;
    for (int i = 0; i < TMO + 3; i++) step($sformatf("rst_mid_quiet%0d", i), s, O_IDLE);
    s.wr_en = 1;
    for (int i = 0; i <= TMO; i++) step($sformatf("rst_mid_restall%0d", i), s, O_STALL);
    s = '0;
    step("rst_mid_retrap", s, O_TRAPB);

    // Random traffic against the behavioural model, starting from reset.
    for (int i = 0; i < 2000; i++) begin
      s = '0;
      s.rst    = (i == 0) || ($urandom_range(0, 99) < 2);
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.rd     = 5'($urandom_range(0, 3));
      s.reg_wr = $urandom_range(0, 1) == 1;
      s.rd_en  = $urandom_range(0, 99) < 30;
      s.wr_en  = $urandom_range(0, 99) < 15;
      s.ack    = $urandom_range(0, 99) < 35;
      s.br     = $urandom_range(0, 99) < 25;
      s.intr   = $urandom_range(0, 99) < 10;
      s.mret   = $urandom_range(0, 99) < 10;
      applyStimulus(s);
      checkOutput($sformatf("rand%0d", i), modelOut(s));
      modelStep(s);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
